// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: fetch datapath defaults and opcode encodings.
package cpu_pkg;

  localparam int unsigned INSTR_W_DEF  = 16;
  localparam int unsigned PC_W_DEF     = 4;
  localparam int unsigned FQ_DEPTH_DEF = 4;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 14;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10
  } opcode_e;

  function automatic logic [1:0] get_opcode(input logic [INSTR_W_DEF-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer with head/tail pointers and occupancy count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEF,
  parameter int unsigned W     = PC_W_DEF + INSTR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             data_in,
  output logic [W-1:0]             data_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  // Pop on an empty queue is dropped so the count can never underflow.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset && !clear) r_mem[r_tail] <= data_in;
  end

  assign data_out = r_mem[r_head];
  assign count    = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, imem addressing and decode handshake over fetch_fifo.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEF,
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [PC_W-1:0]             imem_pc,
  input  logic [INSTR_W-1:0]          imem_instr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTR_W-1:0]          out_instr,
  output logic [PC_W-1:0]             out_pc,
  input  logic                        flush,
  input  logic [PC_W-1:0]             redirect_pc,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned EW = PC_W + INSTR_W;

  logic [PC_W-1:0] r_fetch_pc;
  logic [EW-1:0]   w_entry;
  logic [EW-1:0]   w_head;
  logic            w_full;
  logic            w_pop;
  logic            w_push;

  assign w_full = (fq_count == CW'(FQ_DEPTH));
  assign w_pop  = out_valid && out_ready && !flush;
  // A pop frees the slot in the same edge, so a full queue can still accept.
  assign w_push = !flush && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= '0;
    end else if (flush) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 1'b1;
    end
  end

  assign w_entry = {r_fetch_pc, imem_instr};

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_pop),
    .clear    (flush),
    .data_in  (w_entry),
    .data_out (w_head),
    .count    (fq_count)
  );

  assign imem_pc   = r_fetch_pc;
  assign out_valid = (fq_count != '0);
  assign out_pc    = w_head[INSTR_W +: PC_W];
  assign out_instr = w_head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs queued by stimulus, popped by a monitor.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  imem_pc;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [3:0]  out_pc;
  logic        flush;
  logic [3:0]  redirect_pc;
  logic [2:0]  fq_count;

  int total;
  int bad;
  int pops;
  logic [3:0] exp_q[$];

  fetch_unit #(
    .FQ_DEPTH (4),
    .PC_W     (4),
    .INSTR_W  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_pc     (imem_pc),
    .imem_instr  (imem_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .fq_count    (fq_count)
  );

  assign imem_instr = 16'h1000 + {12'h000, imem_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input int start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'(start + i));
  endtask

  // Monitor: a pop happens on the next edge when valid&ready&!flush at mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (fq_count > 3'd4) begin
        bad++;
        $display("FAIL fq_count_bound: got %0d expected <=4", fq_count);
      end
      if (out_valid && out_ready && !flush) begin
        pops++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_underflow: got pc %0d expected no pop", out_pc);
        end else begin
          automatic logic [3:0] e = exp_q.pop_front();
          if (out_pc !== e || out_instr !== (16'h1000 + {12'h000, e})) begin
            bad++;
            $display("FAIL pop_data: got pc=%0d instr=%h expected pc=%0d instr=%h",
                     out_pc, out_instr, e, 16'h1000 + {12'h000, e});
          end
        end
      end
    end
  end

  initial begin
    int p0;
    total = 0; bad = 0; pops = 0;
    reset = 1'b1; flush = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fq_count, 0);
    chk("rst_imem_pc", imem_pc, 0);

    // Streaming with out_ready=1 from reset release
    exp_q.delete();
    push_seq(0, 24);
    out_ready = 1'b1;
    reset = 1'b0;
    chk("first_imem_pc", imem_pc, 0);
    step();
    p0 = pops;
    chk("stream_valid_c1", out_valid, 1);
    chk("stream_pc_c1", out_pc, 0);
    for (int c = 0; c < 16; c++) begin
      step();
      chk("stream_valid", out_valid, 1);
    end
    chk("stream_pops", pops - p0, 16);
    chk("stream_wrap_pc", out_pc, 0);
    chk("stream_wrap_instr", out_instr, 16'h1000);

    // Fill with out_ready=0, then drain without gaps
    reset = 1'b1; out_ready = 1'b0;
    step();
    exp_q.delete();
    push_seq(0, 12);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("fill_count", fq_count, 4);
    chk("fill_imem_pc", imem_pc, 4);
    chk("fill_head_pc", out_pc, 0);
    for (int c = 0; c < 3; c++) step();
    chk("hold_count", fq_count, 4);
    chk("hold_imem_pc", imem_pc, 4);
    chk("hold_head_pc", out_pc, 0);
    chk("hold_head_instr", out_instr, 16'h1000);
    out_ready = 1'b1;
    p0 = pops;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("drain_count_full", fq_count, 4);
    end
    chk("drain_pops", pops - p0, 5);
    chk("drain_head_pc", out_pc, 5);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    chk("refill_count", fq_count, 4);

    // Flush on a full queue with out_ready=1: head discarded
    flush = 1'b1; redirect_pc = 4'd9; out_ready = 1'b1;
    exp_q.delete();
    push_seq(9, 12);
    p0 = pops;
    step();
    flush = 1'b0;
    chk("flush_count", fq_count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_imem_pc", imem_pc, 9);
    chk("flush_no_pop", pops - p0, 0);
    step();
    chk("flush_head_pc", out_pc, 9);
    chk("flush_head_valid", out_valid, 1);
    for (int c = 0; c < 4; c++) step();
    chk("flush_stream_pc", out_pc, 13);

    // Back-to-back flushes: last redirect wins
    flush = 1'b1; redirect_pc = 4'd3;
    exp_q.delete();
    step();
    redirect_pc = 4'd12;
    exp_q.delete();
    push_seq(12, 12);
    step();
    flush = 1'b0;
    chk("b2b_imem_pc", imem_pc, 12);
    chk("b2b_valid", out_valid, 0);
    step();
    chk("b2b_head_pc", out_pc, 12);
    for (int c = 0; c < 4; c++) step();
    out_ready = 1'b0;

    // Reset (with simultaneous flush) while 3 entries are queued
    reset = 1'b1;
    step();
    exp_q.delete();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) step();
    chk("partial_count", fq_count, 3);
    reset = 1'b1; flush = 1'b1; redirect_pc = 4'd7; out_ready = 1'b1;
    step();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_count", fq_count, 0);
    chk("midrst_imem_pc", imem_pc, 0);
    flush = 1'b0; out_ready = 1'b0;

    // Random back-pressure across several PC wraps
    step();
    exp_q.delete();
    push_seq(0, 90);
    reset = 1'b0;
    p0 = pops;
    for (int c = 0; c < 70; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b0;
    step();
    chk("random_progress", ((pops - p0) > 10) ? 1 : 0, 1);
    chk("random_imem_pc", imem_pc, (pops - p0 + 32'(fq_count)) % 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
